// File: rtl/cpu_pkg.sv
// Shared core types: word width, PC step, fetch FSM states and fetch buffer entries.
package cpu_pkg;

    localparam int WORD_SIZE = 32;
    localparam logic [WORD_SIZE-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: execute redirect, instruction-memory req/ack port, decoder valid/ready port.
interface fetch_unit_if;
    import cpu_pkg::*;

    // imem: imem_req/imem_addr hold until imem_ack (which may be same-cycle combinational);
    // decode: a transfer happens on a cycle with instr_valid & instr_ready, head is stable otherwise.
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_ack;
    logic [WORD_SIZE-1:0] imem_rdata;
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] instr_pc;
    logic                 instr_ready;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             push,
    input  fetch_entry_t                     data_in,
    input  logic                             pop,
    output fetch_entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem request FSM and a small instruction buffer.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                   FIFO_DEPTH = 2,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus,
    output fetch_state_t  state
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_req;
    logic [WORD_SIZE-1:0] pc_inc;
    logic [WORD_SIZE-1:0] redirect_target;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    fetch_entry_t         head;
    fetch_entry_t         entry_in;

    assign pc_inc          = fetch_pc + PC_STEP;
    assign redirect_target = bus.redirect_pc & ~WORD_SIZE'(3);

    // A redirect voids both the push of in-flight data and any decoder pop.
    assign push       = (state == WAIT) & bus.imem_ack & ~bus.redirect & ~full;
    assign pop        = bus.instr_valid & bus.instr_ready & ~bus.redirect;
    assign count_next = count + CW'(push) - CW'(pop & ~empty);

    assign entry_in.pc    = imem_addr;
    assign entry_in.instr = bus.imem_rdata;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.redirect),
        .push    (push),
        .data_in (entry_in),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= '0;
            imem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                    end else if (count < DEPTH_C) begin
                        imem_addr <= fetch_pc;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                        if (bus.imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (bus.imem_ack) begin
                        fetch_pc <= pc_inc;
                        if (count_next < DEPTH_C) begin
                            imem_addr <= pc_inc;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    // The stale request must still complete before a new one may issue.
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                    end
                    if (bus.imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = imem_addr;
    assign bus.instr_valid = ~empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory returning data = address.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic         clk;
    logic         reset;
    fetch_state_t state;
    int           checks;
    int           failures;
    int           lat;
    int           mem_cnt;
    logic         seen_stale;
    logic         got_valid;

    fetch_unit_if bus ();

    fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req && (mem_cnt >= lat);
    assign bus.imem_rdata = bus.imem_addr;

    always @(posedge clk or negedge reset) begin
        if (!reset) mem_cnt <= 0;
        else if (!bus.imem_req || bus.imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int latency, input logic ready);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = ready;
        lat             = latency;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset values, then zero-wait streaming with the decoder always ready.
        do_reset(0, 1'b1);
        reset = 1'b0;
        tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_state", 32'(state), 32'(IDLE));
        reset = 1'b1;
        tick();
        chk("s_e1_req", 32'(bus.imem_req), 32'd1);
        chk("s_e1_addr", bus.imem_addr, 32'h0);
        chk("s_e1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("s_e2_valid", 32'(bus.instr_valid), 32'd1);
        chk("s_e2_pc", bus.instr_pc, 32'h0);
        chk("s_e2_addr", bus.imem_addr, 32'h4);
        tick();
        chk("s_e3_pc", bus.instr_pc, 32'h4);
        chk("s_e3_instr", bus.instr, 32'h4);
        tick();
        chk("s_e4_pc", bus.instr_pc, 32'h8);
        chk("s_e4_addr", bus.imem_addr, 32'hC);

        // Decoder stalled: buffer fills with pc 0 and 4, then fetch idles.
        do_reset(0, 1'b0);
        tick();
        tick();
        tick();
        chk("f_e3_req", 32'(bus.imem_req), 32'd0);
        chk("f_e3_state", 32'(state), 32'(IDLE));
        chk("f_e3_pc", bus.instr_pc, 32'h0);
        tick();
        chk("f_e4_pc", bus.instr_pc, 32'h0);
        chk("f_e4_req", 32'(bus.imem_req), 32'd0);
        bus.instr_ready = 1'b1;
        tick();
        chk("f_e5_pc", bus.instr_pc, 32'h4);
        tick();
        chk("f_e6_req", 32'(bus.imem_req), 32'd1);
        chk("f_e6_addr", bus.imem_addr, 32'h8);
        chk("f_e6_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("f_e7_pc", bus.instr_pc, 32'h8);

        // 3-cycle memory: redirect one cycle after the 0x10 request issues.
        do_reset(3, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h10;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("d_req10", bus.imem_addr, 32'h10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        chk("d_state", 32'(state), 32'(DISCARD));
        chk("d_hold_addr", bus.imem_addr, 32'h10);
        chk("d_hold_req", 32'(bus.imem_req), 32'd1);
        seen_stale = 1'b0;
        got_valid  = 1'b0;
        for (int i = 0; i < 30 && !got_valid; i++) begin
            tick();
            if (bus.instr_valid) begin
                got_valid = 1'b1;
                if (bus.instr_pc == 32'h10) seen_stale = 1'b1;
            end
        end
        chk("d_got_valid", 32'(got_valid), 32'd1);
        chk("d_no_stale", 32'(seen_stale), 32'd0);
        chk("d_new_pc", bus.instr_pc, 32'h100);
        chk("d_new_instr", bus.instr, 32'h100);

        // Redirect coincident with an ack and a decoder pop.
        do_reset(0, 1'b1);
        tick();
        tick();
        tick();
        chk("c_pre_pc", bus.instr_pc, 32'h4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        tick();
        bus.redirect = 1'b0;
        chk("c_valid", 32'(bus.instr_valid), 32'd0);
        chk("c_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("c_addr", bus.imem_addr, 32'h200);
        tick();
        chk("c_pc", bus.instr_pc, 32'h200);

        // Fetch PC wraps modulo 2^32.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("w_addr", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("w_pc0", bus.instr_pc, 32'hFFFF_FFF8);
        tick();
        chk("w_pc1", bus.instr_pc, 32'hFFFF_FFFC);
        chk("w_addr_wrap", bus.imem_addr, 32'h0);
        tick();
        chk("w_pc2", bus.instr_pc, 32'h0);
        chk("w_instr2", bus.instr, 32'h0);

        // Asynchronous reset mid-cycle while a request is pending and the buffer holds data.
        do_reset(3, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("a_pre_valid", 32'(bus.instr_valid), 32'd1);
        chk("a_pre_state", 32'(state), 32'(WAIT));
        chk("a_pre_addr", bus.imem_addr, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("a_req", 32'(bus.imem_req), 32'd0);
        chk("a_valid", 32'(bus.instr_valid), 32'd0);
        chk("a_state", 32'(state), 32'(IDLE));
        lat             = 0;
        bus.instr_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("a_restart_addr", bus.imem_addr, 32'h0);
        chk("a_restart_req", 32'(bus.imem_req), 32'd1);
        tick();
        chk("a_restart_pc", bus.instr_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
